uart_rx_os: RTL
===============

UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; legal values are even and 8..32.
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-005 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have port rx, input, 1, asynchronous serial line; idle high.
REQ-010 SHALL have port data_out, output, DATA_BITS, received word; LSB is the first bit received.
REQ-011 SHALL have port data_valid, output, 1, data_out and the error flags are valid.
REQ-012 SHALL have port data_ready, input, 1, consumer accepts the word.
REQ-013 SHALL have port parity_err, output, 1, parity mismatch on the held word; always 0 when PARITY=0.
REQ-014 SHALL have port frame_err, output, 1, a stop bit was sampled low on the held word.
REQ-015 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer before any use; the synchronizer flops reset to 1.
REQ-017 SHALL generate a sample tick every DIV clocks, DIV = CLK_HZ/(BAUDRATE*OVERSAMPLE) (integer floor); the divider runs only outside IDLE and is cleared on entry to START.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP; all unused encodings return to IDLE.
REQ-019 SHALL go IDLE->START on a 1->0 transition of synchronized rx; a line that stays low without a new high-to-low transition does not start a frame.
REQ-020 SHALL sample the start bit in START after OVERSAMPLE/2 ticks; a sampled 1 is a false start: return to IDLE with no output change.
REQ-021 SHALL thereafter sample every OVERSAMPLE ticks (bit centre): DATA_BITS samples in DATA, shifted LSB first; one sample in PARITY when PARITY!=0, otherwise PARITY is skipped; STOP_BITS samples in STOP.
REQ-022 SHALL set parity_err when PARITY=1 and the XOR of the data bits and the parity bit is 0, or when PARITY=2 and that XOR is 1.
REQ-023 SHALL set frame_err if any stop sample is 0; the frame is still delivered, and the FSM returns to IDLE after the last stop sample.
REQ-024 SHALL load data_out, parity_err and frame_err and assert data_valid exactly 1 clock after the tick of the last stop-bit sample (completion).
REQ-025 SHALL hold data_out, the error flags and data_valid stable while data_valid=1 and data_ready=0.
REQ-026 SHALL deassert data_valid on the clock following a cycle with data_valid=1 and data_ready=1, unless a completion occurs in that same cycle.
REQ-027 SHALL, on a completion while data_valid=1 and data_ready=0, drop the new frame, pulse overrun for one cycle, and leave the held word and flags unchanged.
REQ-028 SHALL, on a completion in the same cycle as an accepting handshake, load the new word, keep data_valid=1, and not pulse overrun.
REQ-029 SHALL keep receiving new frames regardless of data_ready; reception never back-pressures the line.

Reset
REQ-030 SHALL, on a clk edge with rst_n=0, enter IDLE, clear the divider, tick, bit and shift registers, and drive data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0.
REQ-031 SHALL abandon any frame in progress on reset with no output; the first high-to-low transition after rst_n rises starts a new frame.

Verification (CLK_HZ=7_372_800, BAUDRATE=115200, OVERSAMPLE=16: DIV=4, bit period 64 clocks)
REQ-032 SHALL verify 8N1: send 0x47 with data_ready=1 -> one data_valid cycle with data_out=0x47, parity_err=0, frame_err=0.
REQ-033 SHALL verify PARITY=2: send 0x47 with parity bit 1 -> data_out=0x47, parity_err=1; resend with parity bit 0 -> parity_err=0.
REQ-034 SHALL verify glitch rejection: rx low for 20 clocks, then high -> no data_valid and the FSM is back in IDLE.
REQ-035 SHALL verify framing: send 0xA5 with the stop bit low -> data_out=0xA5, frame_err=1; a line held low afterwards starts no further frame.
REQ-036 SHALL verify overrun: data_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun pulses 1 cycle; raise data_ready -> data_valid drops the next cycle.
REQ-037 SHALL verify reset: assert rst_n=0 mid-DATA of 0x3C -> all outputs 0; after release, send 0x5A -> data_out=0x5A, no errors.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with a one-word output holding register.
//
// The serial line is synchronised and then watched for a falling edge. Each
// bit is sampled at its centre using an oversampling tick. The word received
// is presented with ready/valid handshaking. Reception never stalls: if the
// held word has not been taken when a new frame completes, the new frame is
// dropped and overrun pulses for one cycle.
//
// Parameters:
//   CLK_HZ     system clock frequency in Hz
//   BAUDRATE   line bit rate
//   OVERSAMPLE sample ticks per bit (even, 8..32)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   rx         asynchronous serial input, idle high
//   data_out   received word, LSB first on the line
//   data_valid data_out and error flags are valid
//   data_ready consumer accepts the held word
//   parity_err parity mismatch on the held word (0 when PARITY=0)
//   frame_err  a stop bit of the held word was sampled low
//   overrun    one-cycle pulse when a completed frame is dropped
module uart_rx_os #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUDRATE   = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  // A clock slower than BAUDRATE*OVERSAMPLE would floor to zero; tick every clock then.
  localparam int unsigned DIV_RAW = CLK_HZ / (BAUDRATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W    = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = 4;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_FULL_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST    = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST    = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_s1_q, rx_s1_d;
  logic                 rx_s2_q, rx_s2_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick_q, tick_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 fe_q, fe_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic                 rx_fall;
  logic                 sample_now;
  logic                 complete;
  logic                 perr_new;

  always_comb begin
    rx_s1_d   = rx;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
    rx_fall   = rx_prev_q & ~rx_s2_q;

    state_d   = state_q;
    div_d     = div_q;
    tick_d    = 1'b0;
    os_d      = os_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    fe_d      = fe_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = 1'b0;
    complete  = 1'b0;

    // Start bit is sampled after half a bit; every later sample one full bit on.
    sample_now = tick_q &&
                 (os_q == ((state_q == S_START) ? OS_HALF_LAST : OS_FULL_LAST));

    if (state_q != S_IDLE) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
      if (tick_q) begin
        os_d = sample_now ? '0 : os_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        os_d  = '0;
        bit_d = '0;
        par_d = 1'b0;
        fe_d  = 1'b0;
        if (rx_fall) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (sample_now) begin
          state_d = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (sample_now) begin
          shift_d = {rx_s2_q, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ rx_s2_q;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample_now) begin
          par_d   = par_q ^ rx_s2_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_now) begin
          if (!rx_s2_q) begin
            fe_d = 1'b1;
          end
          if (bit_q == STOP_LAST) begin
            bit_d    = '0;
            state_d  = S_IDLE;
            complete = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // par_q already folds in the parity bit: odd expects 1, even expects 0.
    if (PARITY == 1) begin
      perr_new = ~par_q;
    end else if (PARITY == 2) begin
      perr_new = par_q;
    end else begin
      perr_new = 1'b0;
    end

    if (complete && valid_q && !data_ready) begin
      ovr_d = 1'b1;
    end else if (complete) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      perr_d  = perr_new;
      ferr_d  = fe_q | ~rx_s2_q;
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      div_q     <= '0;
      tick_q    <= 1'b0;
      os_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      fe_q      <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_prev_q <= rx_prev_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      fe_q      <= fe_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
